// File: rtl/lib_allocator_output_first_islip.sv
// NxM output-first iSLIP allocator. It runs one request-grant-accept iteration per enabled cycle.
// Round-robin pointers move only on accepts made in the first iteration.
module lib_allocator_output_first_islip #(
  parameter int N = 4,
  parameter int M = 4,
  parameter int ITERATIONS = 2,
  localparam int CW = $clog2(((N < M) ? N : M) + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 i_start,
  input  logic [0:N-1][0:M-1]  i_request,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [0:M-1][0:N-1]  o_grant,
  output logic [CW-1:0]        o_match_count
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [0:N-1][0:M-1] r_req;
  logic [0:M-1][0:N-1] r_match;
  logic [NW-1:0]       r_gptr [M];
  logic [MW-1:0]       r_aptr [N];
  logic [IW-1:0]       r_iter_cnt;

  logic [M-1:0]        w_out_free;
  logic [N-1:0]        w_in_free;
  logic [0:N-1]        w_gcand [M];
  logic [0:M-1]        w_acand [N];
  logic [0:M-1]        w_apick [N];
  logic [0:M-1][0:N-1] w_gnt;
  logic [0:M-1][0:N-1] w_acc;
  logic [0:M-1][0:N-1] w_match_nxt;
  logic                w_any_acc;
  logic                w_last_iter;
  logic                w_start_acc;
  logic                w_busy_d;
  logic                w_done_d;

  function automatic logic [0:N-1] f_pick_in(input logic [0:N-1] cand, input logic [NW-1:0] ptr);
    logic [0:N-1] res;
    logic         found;
    int           idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && cand[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [0:M-1] f_pick_out(input logic [0:M-1] cand, input logic [MW-1:0] ptr);
    logic [0:M-1] res;
    logic         found;
    int           idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < M; k++) begin
      idx = (int'(ptr) + k) % M;
      if (!found && cand[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] f_popcount(input logic [0:M-1][0:N-1] m);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        c = c + CW'(m[j][i]);
      end
    end
    return c;
  endfunction

  always_comb begin
    w_out_free = '0;
    w_in_free  = '0;
    for (int j = 0; j < M; j++) begin
      w_out_free[j] = ~|r_match[j];
    end
    for (int i = 0; i < N; i++) begin
      w_in_free[i] = 1'b1;
      for (int j = 0; j < M; j++) begin
        if (r_match[j][i]) begin
          w_in_free[i] = 1'b0;
        end else begin
          w_in_free[i] = w_in_free[i];
        end
      end
    end
  end

  // Grant phase: each free output offers itself to one free requesting input.
  always_comb begin
    w_gnt = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        w_gcand[j][i] = r_req[i][j] & w_in_free[i] & w_out_free[j];
      end
      w_gnt[j] = f_pick_in(w_gcand[j], r_gptr[j]);
    end
  end

  // Accept phase: each input takes one of its grants; the result is stored in grant orientation.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        w_acand[i][j] = w_gnt[j][i];
      end
      w_apick[i] = f_pick_out(w_acand[i], r_aptr[i]);
      for (int j = 0; j < M; j++) begin
        w_acc[j][i] = w_apick[i][j];
      end
    end
  end

  assign w_match_nxt = r_match | w_acc;
  assign w_any_acc   = |w_acc;
  assign w_last_iter = (r_iter_cnt == IW'(ITERATIONS - 1)) || !w_any_acc;
  assign o_grant     = r_match;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = i_start ? S_ITER : S_IDLE;
      S_ITER:  w_state_nxt = w_last_iter ? S_DONE : S_ITER;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_acc = (r_state == S_IDLE) && i_start;
    w_busy_d    = (w_state_nxt != S_IDLE);
    w_done_d    = (w_state_nxt == S_DONE);
  end

  // Request capture, match accumulation and first-iteration pointer updates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req         <= '0;
      r_match       <= '0;
      r_iter_cnt    <= '0;
      o_match_count <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      for (int j = 0; j < M; j++) r_gptr[j] <= '0;
      for (int i = 0; i < N; i++) r_aptr[i] <= '0;
    end else if (ce) begin
      o_busy <= w_busy_d;
      o_done <= w_done_d;
      if (w_start_acc) begin
        r_req         <= i_request;
        r_match       <= '0;
        r_iter_cnt    <= '0;
        o_match_count <= '0;
      end else if (r_state == S_ITER) begin
        r_match       <= w_match_nxt;
        o_match_count <= f_popcount(w_match_nxt);
        r_iter_cnt    <= r_iter_cnt + IW'(1);
        if (r_iter_cnt == '0) begin
          for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
              if (w_acc[j][i]) begin
                r_gptr[j] <= NW'((i + 1) % N);
                r_aptr[i] <= MW'((j + 1) % M);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lib_allocator_output_first_islip.sv
// Directed bench for the iSLIP allocator: a 2-iteration instance and a 4-iteration instance.
// Expected grants are hand-derived from the round-robin pointer rules.
module tb_lib_allocator_output_first_islip;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              ce;
  logic              start_a, start_b;
  logic [0:3][0:3]   req_a, req_b;
  logic              busy_a, busy_b, done_a, done_b;
  logic [0:3][0:3]   grant_a, grant_b;
  logic [2:0]        cnt_a, cnt_b;

  int checks   = 0;
  int failures = 0;
  int lat;
  int extra;

  lib_allocator_output_first_islip #(.N(4), .M(4), .ITERATIONS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_start(start_a), .i_request(req_a),
    .o_busy(busy_a), .o_done(done_a), .o_grant(grant_a), .o_match_count(cnt_a)
  );

  lib_allocator_output_first_islip #(.N(4), .M(4), .ITERATIONS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .i_start(start_b), .i_request(req_b),
    .o_busy(busy_b), .o_done(done_b), .o_grant(grant_b), .o_match_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle; returns in the o_done cycle with lat = cycles after the start cycle.
  task automatic run_a(input logic [15:0] req, output int l);
    req_a   = req;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    l = 1;
    while (!done_a && l < 40) begin
      step();
      l++;
    end
  endtask

  task automatic run_b(input logic [15:0] req, output int l);
    req_b   = req;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    l = 1;
    while (!done_b && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    req_a   = '0;
    req_b   = '0;
    step();
    step();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    reset_n = 1'b1;
    step();

    // Test 1: all-ones request from reset pointers
    run_a(16'hFFFF, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_grant", 32'(grant_a), 32'h8400);
    chk("t1_count", 32'(cnt_a), 32'd2);
    chk("t1_busy_in_done", 32'(busy_a), 32'd1);
    step();
    chk("t1_done_pulse", 32'(done_a), 32'd0);
    chk("t1_idle_busy", 32'(busy_a), 32'd0);
    chk("t1_grant_hold", 32'(grant_a), 32'h8400);

    // Test 2: same request with pointers advanced by test 1
    run_a(16'hFFFF, lat);
    chk("t2_latency", 32'(lat), 32'd3);
    chk("t2_grant", 32'(grant_a), 32'h4820);
    chk("t2_count", 32'(cnt_a), 32'd3);
    step();

    // Test 3: diagonal request, early exit on the empty second iteration
    run_b(16'h8421, lat);
    chk("t3_latency", 32'(lat), 32'd3);
    chk("t3_grant", 32'(grant_b), 32'h8421);
    chk("t3_count", 32'(cnt_b), 32'd4);
    step();

    // Test 4: empty request leaves pointers untouched
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    run_a(16'h0000, lat);
    chk("t4_latency", 32'(lat), 32'd2);
    chk("t4_grant", 32'(grant_a), 32'h0);
    chk("t4_count", 32'(cnt_a), 32'd0);
    step();
    run_a(16'hFFFF, lat);
    chk("t4_rerun_latency", 32'(lat), 32'd3);
    chk("t4_rerun_grant", 32'(grant_a), 32'h8400);
    chk("t4_rerun_count", 32'(cnt_a), 32'd2);
    step();

    // Test 5: ce low for three ITER cycles; request changed after capture
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    req_a   = 16'hFFFF;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    req_a   = 16'h0000;
    ce      = 1'b0;
    step();
    step();
    step();
    ce = 1'b1;
    chk("t5_frozen_busy", 32'(busy_a), 32'd1);
    chk("t5_frozen_done", 32'(done_a), 32'd0);
    lat = 4;
    while (!done_a && lat < 40) begin
      step();
      lat++;
    end
    chk("t5_latency", 32'(lat), 32'd6);
    chk("t5_grant", 32'(grant_a), 32'h8400);
    chk("t5_count", 32'(cnt_a), 32'd2);
    ce = 1'b0;
    step();
    step();
    chk("t5_done_held", 32'(done_a), 32'd1);
    ce = 1'b1;
    step();
    chk("t5_done_drop", 32'(done_a), 32'd0);

    // Test 6: reset mid-ITER, then start held high while busy
    req_a   = 16'hFFFF;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_grant", 32'(grant_a), 32'h0);
    chk("t6_rst_done", 32'(done_a), 32'd0);
    start_a = 1'b1;
    step();
    chk("t6_busy_iter0", 32'(busy_a), 32'd1);
    step();
    chk("t6_busy_iter1", 32'(done_a), 32'd0);
    step();
    chk("t6_done", 32'(done_a), 32'd1);
    start_a = 1'b0;
    chk("t6_grant", 32'(grant_a), 32'h8400);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done_a) extra++;
    end
    chk("t6_no_extra_done", 32'(extra), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
